// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared datapath width, ALU opcode map and exec FSM state type
package cpu16_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_ADDI = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SLT  = 4'h8,
    OP_MUL  = 4'h9
  } opcode_e;
  typedef enum logic {ST_IDLE, ST_MUL} state_e;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle combinational ALU; multiply is sequenced elsewhere and decodes to zero here
module alu_comb
  import cpu16_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);
  logic [DATA_W-1:0] sum, diff;
  assign sum  = A + B;
  assign diff = A - B;
  // opcode decode; unused codes pass B through
  always_comb begin
    result   = B;
    overflow = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        result   = sum;
        overflow = (A[DATA_W-1] == B[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (A[DATA_W-1] != B[DATA_W-1]) && (diff[DATA_W-1] != A[DATA_W-1]);
      end
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_SLL:  result = A << B[3:0];
      OP_SRL:  result = A >> B[3:0];
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(A) < $signed(B)};
      OP_MUL:  result = '0;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with output registers; ALU_EXEC_MUL_EN adds a 16-step shift-add multiplier
module alu_exec #(
  parameter int DATA_W = cpu16_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        opcode,
  output logic              out_valid,
  output logic [DATA_W-1:0] Result,
  output logic              Zero,
  output logic              Overflow
);
  logic [DATA_W-1:0] alu_res, mul_res, next_res;
  logic              alu_ovf, mul_ovf, fire, mul_go, mul_done, single;
  alu_comb u_alu (.A(A), .B(B), .opcode(opcode), .result(alu_res), .overflow(alu_ovf));
  assign fire = in_valid && in_ready;
`ifdef ALU_EXEC_MUL_EN
  cpu16_pkg::state_e   state, state_next;
  logic [DATA_W-1:0]   mul_a, mul_b;
  logic [2*DATA_W-1:0] acc, acc_next;
  logic [3:0]          cnt;
  assign in_ready = state == cpu16_pkg::ST_IDLE;
  assign mul_go   = fire && opcode == cpu16_pkg::OP_MUL;
  assign mul_done = state == cpu16_pkg::ST_MUL && cnt == 4'hf;
  assign acc_next = acc + (mul_b[cnt] ? ({{DATA_W{1'b0}}, mul_a} << cnt) : '0);
  assign mul_res  = acc_next[DATA_W-1:0];
  assign mul_ovf  = |acc_next[2*DATA_W-1:DATA_W];
  // next state: enter MUL on an accepted multiply, return after the last step
  always_comb begin
    state_next = state;
    if (mul_go) state_next = cpu16_pkg::ST_MUL;
    else if (mul_done) state_next = cpu16_pkg::ST_IDLE;
  end
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= cpu16_pkg::ST_IDLE;
    else state <= state_next;
  // multiplier datapath: latch operands on accept, then add one shifted partial product per edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (mul_go) begin
      mul_a <= A;
      mul_b <= B;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == cpu16_pkg::ST_MUL) begin
      acc <= acc_next;
      cnt <= cnt + 4'd1;
    end
`else
  assign in_ready = 1'b1;
  assign mul_go   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_ovf  = 1'b0;
`endif
  assign single   = fire && !mul_go;
  assign next_res = mul_done ? mul_res : alu_res;
  // output registers: load on a single-cycle accept or the final multiply step, hold otherwise
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      out_valid <= single || mul_done;
      if (single || mul_done) begin
        Result   <= next_res;
        Zero     <= next_res == '0;
        Overflow <= mul_done ? mul_ovf : alu_ovf;
      end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec; multiply checks follow ALU_EXEC_MUL_EN
module tb_alu_exec;
  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        v;
    int          due;
  } exp_t;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic        clock = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic        in_ready, out_valid, Zero, Overflow;
  logic [15:0] A = '0, B = '0, Result;
  logic [3:0]  opcode = '0;
  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0, cyc = 0, busy_seen = 0;
  logic [17:0] hold = '0;

  alu_exec #(.DATA_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid),
    .Result(Result), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          sa, sbv, s;
    logic [31:0] p;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    p   = {16'h0, a} * {16'h0, b};
    e.v = 1'b0;
    e.due = 0;
    case (op)
      4'd0, 4'd2: begin s = sa + sbv; e.res = 16'(s); e.v = s > 32767 || s < -32768; end
      4'd1: begin s = sa - sbv; e.res = 16'(s); e.v = s > 32767 || s < -32768; end
      4'd3: e.res = a & b;
      4'd4: e.res = a | b;
      4'd5: e.res = a ^ b;
      4'd6: e.res = a << b[3:0];
      4'd7: e.res = a >> b[3:0];
      4'd8: e.res = (sa < sbv) ? 16'd1 : 16'd0;
      4'd9: begin
        e.res = MUL_EN ? p[15:0] : 16'h0;
        e.v   = MUL_EN && p[31:16] != 16'h0;
      end
      default: e.res = b;
    endcase
    e.z = e.res == 16'h0;
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(op, a, b);
    check("ready", in_ready, 1);
    e.due = cyc + 1 + ((op == 4'd9 && MUL_EN) ? 16 : 0);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clock);
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      check("rst_out", {out_valid, Result, Zero, Overflow, in_ready}, {1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
      hold = '0;
    end else if (out_valid) begin
      if (sb.size() == 0) check("spurious", out_valid, 0);
      else begin
        e = sb.pop_front();
        check("lat", cyc, e.due);
        check("result", Result, e.res);
        check("zero", Zero, e.z);
        check("ovf", Overflow, e.v);
        hold = {e.res, e.z, e.v};
      end
    end else begin
      check("hold", {Result, Zero, Overflow}, hold);
      if (!in_ready) busy_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    repeat (3) @(negedge clock);
    check("rst_ready", in_ready, 1);
    #2 reset = 1'b1;
    @(negedge clock);
    check("idle_out", {out_valid, Result, Zero, Overflow, in_ready}, {1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
    send(4'd0, 16'h7fff, 16'h0001); @(negedge clock);
    send(4'd1, 16'h0005, 16'h0005); @(negedge clock);
    send(4'd6, 16'h0001, 16'hfff3); @(negedge clock);
    send(4'd8, 16'hffff, 16'h0001); @(negedge clock);
    send(4'd15, 16'h0000, 16'habcd); @(negedge clock);
    send(4'd0, 16'h8000, 16'h8000); @(negedge clock);
    send(4'd1, 16'h8000, 16'h0001); @(negedge clock);
    send(4'd7, 16'h8000, 16'h000f); @(negedge clock);
    send(4'd6, 16'h1234, 16'h0010); @(negedge clock);
    send(4'd8, 16'h0001, 16'hffff); @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd9 && MUL_EN) op = 4'd5;
      send(op, 16'($urandom), 16'($urandom));
      @(negedge clock);
    end
    in_valid = 1'b0;
    drain();
`ifdef ALU_EXEC_MUL_EN
    send(4'd9, 16'h0100, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("busy", in_ready, 0);
      in_valid = i < 15;
      opcode   = 4'd0;
      A        = 16'h0001;
      B        = 16'h0001;
    end
    drain();
    send(4'd9, 16'h0003, 16'h0005); @(negedge clock);
    in_valid = 1'b0;
    drain();
    send(4'd9, 16'hffff, 16'hffff); @(negedge clock);
    in_valid = 1'b0;
    drain();
    send(4'd9, 16'h00ff, 16'h00ff); @(negedge clock);
    in_valid = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b0;
    sb.delete();
    @(negedge clock);
    check("abort", {out_valid, Result, Zero, Overflow, in_ready}, {1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    send(4'd0, 16'h0002, 16'h0003); @(negedge clock);
    in_valid = 1'b0;
    drain();
`else
    send(4'd9, 16'h0003, 16'h0005); @(negedge clock);
    in_valid = 1'b0;
    drain();
    check("never_busy", busy_seen, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
